// File: rtl/serial_adder_if.sv
// serial_adder_if: start/busy/done handshake and operand/result bus; sub exists only with SERIAL_ADDER_SUB_EN
interface serial_adder_if #(parameter int WIDTH = 16);
  logic             start;
  logic             cin;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
`ifdef SERIAL_ADDER_SUB_EN
  logic             sub;
  modport master(output start, a, b, cin, sub, input busy, done, sum, cout, ovf);
  modport slave(input start, a, b, cin, sub, output busy, done, sum, cout, ovf);
`else
  modport master(output start, a, b, cin, input busy, done, sum, cout, ovf);
  modport slave(input start, a, b, cin, output busy, done, sum, cout, ovf);
`endif
endinterface

// File: rtl/serial_adder.sv
// serial_adder: multi-cycle adder, DIGIT bits per clock; SERIAL_ADDER_SUB_EN adds a subtract mode
module serial_adder #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 1
) (
  input logic          clk,
  input logic          rst,
  serial_adder_if.slave bus
);
  localparam int N  = WIDTH / DIGIT;
  localparam int CW = $clog2(N + 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t                 state_q, state_d;
  logic [WIDTH-1:0]       a_q, a_d, b_q, b_d, sum_q, sum_d, b_in;
  logic                   carry_q, carry_d, cout_q, cout_d, ovf_q, ovf_d, cin_in;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [DIGIT:0]         slice;
  logic [WIDTH+DIGIT-1:0] shifted;
`ifdef SERIAL_ADDER_SUB_EN
  assign b_in   = bus.sub ? ~bus.b : bus.b;
  assign cin_in = bus.sub | bus.cin;
`else
  assign b_in   = bus.b;
  assign cin_in = bus.cin;
`endif
  always_comb begin
    slice   = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry_q};
    shifted = {slice[DIGIT-1:0], sum_q};
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;
    if (state_q != RUN && bus.start) begin
      state_d = RUN;
      a_d     = bus.a;
      b_d     = b_in;
      carry_d = cin_in;
      cnt_d   = '0;
    end else if (state_q == RUN) begin
      a_d     = a_q >> DIGIT;
      b_d     = b_q >> DIGIT;
      sum_d   = WIDTH'(shifted >> DIGIT);
      carry_d = slice[DIGIT];
      cnt_d   = cnt_q + CW'(1);
      if (cnt_q == CW'(N - 1)) begin
        state_d = DONE;
        cout_d  = slice[DIGIT];
        // carry into the MSB recovered as a ^ b ^ sum of that bit
        ovf_d   = slice[DIGIT] ^ a_q[DIGIT-1] ^ b_q[DIGIT-1] ^ slice[DIGIT-1];
      end
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end
  assign bus.busy = state_q == RUN;
  assign bus.done = state_q == DONE;
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
  assign bus.ovf  = ovf_q;
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: random and directed checks of serial_adder for DIGIT in {1,2,4,8,16} against an arithmetic model
module tb_serial_adder;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        cin = 1'b0;
  logic        sub = 1'b0;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        busy_w[5], done_w[5], cout_w[5], ovf_w[5];
  logic [15:0] sum_w[5];
  int          checks = 0;
  int          errors = 0;
  always #5 clk = ~clk;
  for (genvar i = 0; i < 5; i++) begin : g
    serial_adder_if #(.WIDTH(16)) bus ();
    assign bus.start = start;
    assign bus.a     = a;
    assign bus.b     = b;
    assign bus.cin   = cin;
`ifdef SERIAL_ADDER_SUB_EN
    assign bus.sub   = sub;
`endif
    assign busy_w[i] = bus.busy;
    assign done_w[i] = bus.done;
    assign sum_w[i]  = bus.sum;
    assign cout_w[i] = bus.cout;
    assign ovf_w[i]  = bus.ovf;
    serial_adder #(.WIDTH(16), .DIGIT(1 << i)) dut (.clk(clk), .rst(rst), .bus(bus));
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  // returns {ovf, cout, sum}
  function automatic logic [17:0] model(input logic [15:0] ma, input logic [15:0] mb, input logic mc, input logic ms);
    logic [15:0] bb;
    logic [16:0] f;
    logic        v;
    bb = ms ? ~mb : mb;
    f  = {1'b0, ma} + {1'b0, bb} + {16'd0, ms | mc};
    v  = (ma[15] == bb[15]) && (f[15] != ma[15]);
    return {v, f};
  endfunction
  task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_, input logic tc, input logic ts);
    logic [17:0] e;
    int done_at[5], pulses[5], n;
    bit busy_ok[5];
    e = model(ta, tb_, tc, ts);
    @(negedge clk);
    a = ta; b = tb_; cin = tc; sub = ts; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom); sub = 1'($urandom);
    for (int d = 0; d < 5; d++) begin
      done_at[d] = -1; pulses[d] = 0; busy_ok[d] = 1'b1;
    end
    for (int j = 0; j < 20; j++) begin
      for (int d = 0; d < 5; d++) begin
        n = 16 >> d;
        if (busy_w[d] !== (j < n)) busy_ok[d] = 1'b0;
        if (done_w[d] === 1'b1) begin
          pulses[d]++;
          if (done_at[d] < 0) done_at[d] = j;
        end
      end
      @(negedge clk);
    end
    for (int d = 0; d < 5; d++) begin
      check($sformatf("d%0d_latency", 1 << d), done_at[d], 16 >> d);
      check($sformatf("d%0d_pulses", 1 << d), pulses[d], 1);
      check($sformatf("d%0d_busy", 1 << d), {31'd0, busy_ok[d]}, 1);
      check($sformatf("d%0d_sum", 1 << d), {16'd0, sum_w[d]}, {16'd0, e[15:0]});
      check($sformatf("d%0d_cout", 1 << d), {31'd0, cout_w[d]}, {31'd0, e[16]});
      check($sformatf("d%0d_ovf", 1 << d), {31'd0, ovf_w[d]}, {31'd0, e[17]});
    end
  endtask
  initial begin
    logic [17:0] e;
    bit seen;
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 5; d++) begin
      check("rst_busy", {31'd0, busy_w[d]}, 0);
      check("rst_done", {31'd0, done_w[d]}, 0);
      check("rst_sum", {16'd0, sum_w[d]}, 0);
      check("rst_cout_ovf", {30'd0, cout_w[d], ovf_w[d]}, 0);
    end
    rst = 1'b0;
    run_op(16'h0003, 16'h0004, 1'b0, 1'b0);
    check("t1_sum", {16'd0, sum_w[0]}, 32'h0007);
    run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    check("t2a", {14'd0, ovf_w[0], cout_w[0], sum_w[0]}, {14'd0, 2'b01, 16'h0000});
    run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0);
    check("t2b", {14'd0, ovf_w[0], cout_w[0], sum_w[0]}, {14'd0, 2'b10, 16'h8000});
    run_op(16'h1234, 16'h0FFF, 1'b1, 1'b0);
    check("t5_d4", {15'd0, cout_w[2], sum_w[2]}, {15'd0, 1'b0, 16'h2234});
    for (int k = 0; k < 10; k++)
      run_op(16'($urandom), 16'($urandom), 1'($urandom), 1'b0);
    // start held high: back-to-back accept in the DONE cycle
    @(negedge clk);
    a = 16'h1111; b = 16'h2222; cin = 1'b0; sub = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    for (int j = 0; j < 16; j++) begin
      a = 16'($urandom); b = 16'($urandom);
      @(negedge clk);
    end
    e = model(16'h1111, 16'h2222, 1'b0, 1'b0);
    check("t3_done1", {31'd0, done_w[0]}, 1);
    check("t3_sum1", {16'd0, sum_w[0]}, {16'd0, e[15:0]});
    a = 16'h8001; b = 16'h9003; cin = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    check("t3_busy2", {31'd0, busy_w[0]}, 1);
    a = 16'($urandom); b = 16'($urandom);
    repeat (16) @(negedge clk);
    e = model(16'h8001, 16'h9003, 1'b1, 1'b0);
    check("t3_done2", {31'd0, done_w[0]}, 1);
    check("t3_res2", {14'd0, e[17], e[16], e[15:0]}, {14'd0, ovf_w[0], cout_w[0], sum_w[0]});
    // abort mid-run with reset
    @(negedge clk);
    a = 16'hABCD; b = 16'h1234; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("t4_busy", {31'd0, busy_w[0]}, 0);
    check("t4_done", {31'd0, done_w[0]}, 0);
    check("t4_sum", {16'd0, sum_w[0]}, 0);
    rst = 1'b0;
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (done_w[0] === 1'b1) seen = 1'b1;
    end
    check("t4_no_done", {31'd0, seen}, 0);
    run_op(16'($urandom), 16'($urandom), 1'($urandom), 1'b0);
`ifdef SERIAL_ADDER_SUB_EN
    run_op(16'h0005, 16'h0007, 1'b0, 1'b1);
    check("t6a", {14'd0, ovf_w[0], cout_w[0], sum_w[0]}, {14'd0, 2'b00, 16'hFFFE});
    run_op(16'h8000, 16'h0001, 1'b0, 1'b1);
    check("t6b", {14'd0, ovf_w[0], cout_w[0], sum_w[0]}, {14'd0, 2'b11, 16'h7FFF});
    for (int k = 0; k < 6; k++)
      run_op(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
